cordic_log_sched: RTL

- Scheduler and arbiter that shares one cordic_log pipeline (fix32_24 natural-log output) between NREQ requesters.
- The pipeline advances only on cycles where its valid-in is high. This block therefore owns that strobe:
  - it issues requests from a round-robin arbiter;
  - it injects zero-data bubbles to drain in-flight work;
  - it tracks requester tags in a shift register that runs in lockstep with the pipeline;
  - it routes each result back to its requester.
- Sits between the requester clients and a single cordic_log instance at top level.

---
 rtl/cordic_log_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cordic_log_sched.sv
// Round-robin scheduler sharing one cordic_log pipeline between NREQ requesters.
// Optional per-requester grant counters: define CORDIC_LOG_SCHED_STATS_EN.
module cordic_log_sched #(
    parameter int NREQ  = 4,
    parameter int WD    = 32,
    parameter int DEPTH = 24
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*WD-1:0]   i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [NREQ-1:0]      o_rsp_valid,
    output logic [31:0]          o_rsp_data,
    output logic                 o_rsp_err,
    output logic                 o_busy,
    output logic                 o_sync_err,
`ifdef CORDIC_LOG_SCHED_STATS_EN
    output logic [NREQ*16-1:0]   o_stat_cnt,
`endif
    output logic                 p_adv,
    output logic [WD-1:0]        p_data,
    input  logic                 p_res_valid,
    input  logic [31:0]          p_res_data
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                      r_state;
    logic [IDW-1:0]              r_ptr;
    logic [DEPTH-1:0]            r_vld_pipe;
    logic [DEPTH-1:0]            r_zero_pipe;
    logic [DEPTH-1:0][IDW-1:0]   r_id_pipe;

    logic                        w_gnt;
    logic [IDW-1:0]              w_gnt_id;
    logic [IDW:0]                w_idx;
    logic [NREQ-1:0]             w_ready;
    logic [WD-1:0]               w_opnd;
    logic                        w_adv;
    logic                        w_empty_after;
    logic                        w_exp_res;

    // Round-robin search starting at r_ptr; no grants while reset is asserted.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
            if (w_idx >= (IDW+1)'(NREQ))
                w_idx = w_idx - (IDW+1)'(NREQ);
            if (!w_gnt && i_req_valid[w_idx[IDW-1:0]]) begin
                w_gnt    = 1'b1;
                w_gnt_id = w_idx[IDW-1:0];
            end
        end
        if (i_arst)
            w_gnt = 1'b0;
    end

    always_comb begin
        w_ready = '0;
        for (int k = 0; k < NREQ; k++)
            w_ready[k] = w_gnt && (w_gnt_id == IDW'(k));
    end

    assign w_opnd        = i_req_data[w_gnt_id*WD +: WD];
    assign w_adv         = w_gnt || (r_state != S_IDLE);
    assign w_empty_after = ~|r_vld_pipe[DEPTH-2:0];
    // Pipeline reports valid only for real non-zero operands.
    assign w_exp_res     = r_vld_pipe[DEPTH-1] && !r_zero_pipe[DEPTH-1];

    assign o_req_ready = w_ready;
    assign p_adv       = w_adv;
    assign p_data      = w_gnt ? w_opnd : '0;
    assign o_busy      = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_vld_pipe  <= '0;
            r_zero_pipe <= '0;
            r_id_pipe   <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
            o_sync_err  <= 1'b0;
        end else begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;

            if (w_gnt)
                r_ptr <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;

            if (w_adv) begin
                r_vld_pipe  <= {r_vld_pipe[DEPTH-2:0], w_gnt};
                r_zero_pipe <= {r_zero_pipe[DEPTH-2:0], w_gnt && (w_opnd == '0)};
                r_id_pipe   <= {r_id_pipe[DEPTH-2:0], w_gnt_id};
                if (r_vld_pipe[DEPTH-1]) begin
                    o_rsp_valid[r_id_pipe[DEPTH-1]] <= 1'b1;
                    if (r_zero_pipe[DEPTH-1]) begin
                        o_rsp_err  <= 1'b1;
                        o_rsp_data <= 32'h8000_0000;
                    end else begin
                        o_rsp_data <= p_res_data;
                    end
                end
                if (w_exp_res != p_res_valid)
                    o_sync_err <= 1'b1;
            end

            case (r_state)
                S_IDLE:  if (w_gnt) r_state <= S_RUN;
                default: begin
                    if (w_gnt)              r_state <= S_RUN;
                    else if (w_empty_after) r_state <= S_IDLE;
                    else                    r_state <= S_DRAIN;
                end
            endcase
        end
    end

`ifdef CORDIC_LOG_SCHED_STATS_EN
    logic [NREQ-1:0][15:0] r_stat;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_stat <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++)
                if (w_ready[k] && r_stat[k] != 16'hFFFF)
                    r_stat[k] <= r_stat[k] + 16'd1;
        end
    end

    assign o_stat_cnt = r_stat;
`endif

endmodule
